// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and
// default frame parameters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous rx line.
// Ports: clk, reset_n, d (async in), q (sync out), both flops reset to 1.
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB first, configurable data/stop length.
// Ports: clk, reset_n, rx, s_tick in; rx_done_tick, dout, frame_err, busy out.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       s_tick,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err,
  output logic       busy
);

  // Stop bits longer than one need a wider tick counter.
  localparam int SW = (SB_TICK > 16) ? 5 : 4;

  logic          rx_s;
  rx_state_t     state, state_n;
  logic [SW-1:0] s, s_n;
  logic [2:0]    n, n_n;
  logic [7:0]    b, b_n;
  logic [7:0]    dout_n;
  logic          ferr_n;
  logic          done_n;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state        <= state_n;
      s            <= s_n;
      n            <= n_n;
      b            <= b_n;
      dout         <= dout_n;
      frame_err    <= ferr_n;
      rx_done_tick <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s;
    n_n     = n;
    b_n     = b;
    dout_n  = dout;
    ferr_n  = frame_err;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == SW'(7)) begin
            s_n = '0;
            if (!rx_s) begin
              state_n = DATA;
              n_n     = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_n = '0;
            b_n = {rx_s, b[7:1]};
            if (n == 3'(DBIT - 1)) begin
              state_n = STOP;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
            // Short words land in the top of b; realign to LSB.
            dout_n  = b >> (8 - DBIT);
            ferr_n  = ~rx_s;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: two instances (8N1 and 7 data/2 stop).
// Serial stimulus is aligned to the oversampling tick stream.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick = 1'b0;
  logic       rx_line = 1'b1;
  logic       sel7 = 1'b0;
  logic       rx8, rx7;
  logic       done8, ferr8, busy8;
  logic [7:0] dout8;
  logic       done7, ferr7, busy7;
  logic [7:0] dout7;

  int n_checks = 0;
  int n_fail = 0;
  int tick_num = 0;
  int start_tick = 0;
  int done_cnt = 0;
  int last_done = 0;
  int prev_done = 0;
  logic [7:0] cap_dout = 8'h00;
  logic       cap_ferr = 1'b0;
  int done7_cnt = 0;
  int last7_done = 0;
  logic [7:0] cap7_dout = 8'h00;
  logic       cap7_ferr = 1'b0;

  assign rx8 = sel7 ? 1'b1 : rx_line;
  assign rx7 = sel7 ? rx_line : 1'b1;

  uart_rx #(.DBIT(8), .SB_TICK(16)) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx8),
    .s_tick       (s_tick),
    .rx_done_tick (done8),
    .dout         (dout8),
    .frame_err    (ferr8),
    .busy         (busy8)
  );

  uart_rx #(.DBIT(7), .SB_TICK(32)) u_dut7 (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx7),
    .s_tick       (s_tick),
    .rx_done_tick (done7),
    .dout         (dout7),
    .frame_err    (ferr7),
    .busy         (busy7)
  );

  always #5 clk = ~clk;

  // One tick every 5 clocks.
  initial begin
    int tdiv;
    tdiv = 0;
    forever begin
      @(negedge clk);
      s_tick = (tdiv == 4);
      tdiv = (tdiv == 4) ? 0 : tdiv + 1;
    end
  end

  always @(posedge clk) begin
    if (s_tick) tick_num <= tick_num + 1;
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      done_cnt  = done_cnt + 1;
      cap_dout  = dout8;
      cap_ferr  = ferr8;
      prev_done = last_done;
      last_done = tick_num;
    end
    if (done7 === 1'b1) begin
      done7_cnt  = done7_cnt + 1;
      cap7_dout  = dout7;
      cap7_ferr  = ferr7;
      last7_done = tick_num;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int k);
    repeat (k) begin
      do @(posedge clk); while (s_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic send_bit(input logic v, input int k);
    rx_line = v;
    wait_ticks(k);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits,
                            input logic stop_v, input int stop_k);
    start_tick = tick_num;
    send_bit(1'b0, 16);
    for (int i = 0; i < nbits; i++) send_bit(data[i], 16);
    send_bit(stop_v, stop_k);
  endtask

  task automatic test_reset();
    rx_line = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (dout8 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dout: got %h expected 00", dout8);
    end
    n_checks++;
    if (done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b expected 0", done8);
    end
    n_checks++;
    if (ferr8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ferr: got %b expected 0", ferr8);
    end
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b expected 0", busy8);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(4);
  endtask

  task automatic test_frame_a5();
    int c0;
    c0 = done_cnt;
    send_frame(8'hA5, 8, 1'b1, 16);
    wait_ticks(20);
    n_checks++;
    if (done_cnt !== c0 + 1) begin
      n_fail++;
      $display("FAIL a5_done_cnt: got %0d expected %0d", done_cnt, c0 + 1);
    end
    n_checks++;
    if (cap_dout !== 8'hA5) begin
      n_fail++;
      $display("FAIL a5_dout: got %h expected a5", cap_dout);
    end
    n_checks++;
    if (cap_ferr !== 1'b0) begin
      n_fail++;
      $display("FAIL a5_ferr: got %b expected 0", cap_ferr);
    end
    n_checks++;
    if (last_done - start_tick !== 152) begin
      n_fail++;
      $display("FAIL a5_latency: got %0d ticks expected 152", last_done - start_tick);
    end
    n_checks++;
    if (busy8 !== 1'b0 || dout8 !== 8'hA5) begin
      n_fail++;
      $display("FAIL a5_hold: got busy=%b dout=%h expected busy=0 dout=a5", busy8, dout8);
    end
  endtask

  task automatic test_glitch();
    int c0;
    c0 = done_cnt;
    rx_line = 1'b0;
    wait_ticks(4);
    rx_line = 1'b1;
    wait_ticks(3);
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy_s6: got %b expected 1", busy8);
    end
    wait_ticks(1);
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_idle_s7: got %b expected 0", busy8);
    end
    wait_ticks(10);
    n_checks++;
    if (done_cnt !== c0) begin
      n_fail++;
      $display("FAIL glitch_no_done: got %0d expected %0d", done_cnt, c0);
    end
    n_checks++;
    if (dout8 !== 8'hA5) begin
      n_fail++;
      $display("FAIL glitch_dout: got %h expected a5", dout8);
    end
  endtask

  task automatic test_frame_err();
    int c0;
    c0 = done_cnt;
    // Stop held low briefly, then line released before the next sample.
    send_frame(8'h3C, 8, 1'b0, 12);
    rx_line = 1'b1;
    wait_ticks(20);
    n_checks++;
    if (done_cnt !== c0 + 1) begin
      n_fail++;
      $display("FAIL ferr_done_cnt: got %0d expected %0d", done_cnt, c0 + 1);
    end
    n_checks++;
    if (cap_dout !== 8'h3C) begin
      n_fail++;
      $display("FAIL ferr_dout: got %h expected 3c", cap_dout);
    end
    n_checks++;
    if (cap_ferr !== 1'b1) begin
      n_fail++;
      $display("FAIL ferr_flag: got %b expected 1", cap_ferr);
    end
    n_checks++;
    if (ferr8 !== 1'b1 || busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL ferr_hold: got ferr=%b busy=%b expected ferr=1 busy=0", ferr8, busy8);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [7:0] first;
    c0 = done_cnt;
    send_frame(8'h00, 8, 1'b1, 16);
    first = cap_dout;
    send_frame(8'hFF, 8, 1'b1, 16);
    wait_ticks(20);
    n_checks++;
    if (done_cnt !== c0 + 2) begin
      n_fail++;
      $display("FAIL b2b_done_cnt: got %0d expected %0d", done_cnt, c0 + 2);
    end
    n_checks++;
    if (first !== 8'h00) begin
      n_fail++;
      $display("FAIL b2b_first: got %h expected 00", first);
    end
    n_checks++;
    if (cap_dout !== 8'hFF) begin
      n_fail++;
      $display("FAIL b2b_second: got %h expected ff", cap_dout);
    end
    n_checks++;
    if (last_done - prev_done !== 160) begin
      n_fail++;
      $display("FAIL b2b_spacing: got %0d ticks expected 160", last_done - prev_done);
    end
    n_checks++;
    if (ferr8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_ferr: got %b expected 0", ferr8);
    end
  endtask

  task automatic test_reset_midframe();
    int c0;
    send_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 16);
    rx_line = 1'b1;
    wait_ticks(8);
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_busy_pre: got %b expected 1", busy8);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (dout8 !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_rst_dout: got %h expected 00", dout8);
    end
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || ferr8 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_flags: got busy=%b done=%b ferr=%b expected 0 0 0",
               busy8, done8, ferr8);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(20);
    c0 = done_cnt;
    send_frame(8'h5A, 8, 1'b1, 16);
    wait_ticks(20);
    n_checks++;
    if (done_cnt !== c0 + 1) begin
      n_fail++;
      $display("FAIL mid_5a_done: got %0d expected %0d", done_cnt, c0 + 1);
    end
    n_checks++;
    if (cap_dout !== 8'h5A || cap_ferr !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_5a_data: got dout=%h ferr=%b expected 5a 0", cap_dout, cap_ferr);
    end
  endtask

  task automatic test_sync_release();
    reset_n = 1'b0;
    rx_line = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_early: got busy=%b expected 0", busy8);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_start: got busy=%b expected 1", busy8);
    end
    reset_n = 1'b0;
    rx_line = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(20);
  endtask

  task automatic test_dbit7_2stop();
    int c8;
    c8 = done_cnt;
    sel7 = 1'b1;
    send_frame(8'h55, 7, 1'b1, 32);
    wait_ticks(20);
    sel7 = 1'b0;
    n_checks++;
    if (done7_cnt !== 1) begin
      n_fail++;
      $display("FAIL d7_done_cnt: got %0d expected 1", done7_cnt);
    end
    n_checks++;
    if (cap7_dout !== 8'h55) begin
      n_fail++;
      $display("FAIL d7_dout: got %h expected 55", cap7_dout);
    end
    n_checks++;
    if (cap7_ferr !== 1'b0) begin
      n_fail++;
      $display("FAIL d7_ferr: got %b expected 0", cap7_ferr);
    end
    n_checks++;
    if (last7_done - start_tick !== 152) begin
      n_fail++;
      $display("FAIL d7_latency: got %0d ticks expected 152", last7_done - start_tick);
    end
    n_checks++;
    if (busy7 !== 1'b0 || done_cnt !== c8) begin
      n_fail++;
      $display("FAIL d7_idle: got busy7=%b done8_cnt=%0d expected 0 %0d",
               busy7, done_cnt, c8);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_midframe();
    test_sync_release();
    test_dbit7_2stop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
